// File: rtl/display_pkg.sv
// ============================================================================
// Module   : display_pkg
// Brief    : Shared framebuffer geometry, fill FSM states and chunk sizes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package display_pkg;

    localparam int unsigned c_FB_WIDTH  = 320;
    localparam int unsigned c_FB_HEIGHT = 240;
    localparam logic [31:0] c_BASE_ADDR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } fill_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } chunk_size_t;

endpackage

`default_nettype wire

// File: rtl/rect_chunk_sel.sv
// ============================================================================
// Module   : rect_chunk_sel
// Brief    : Picks the largest aligned write (word/half/byte) that fits in
//            the remaining span of a row.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rect_chunk_sel
    import display_pkg::*;
(
    input  logic [1:0]  i_x,
    input  logic [11:0] i_rem,
    output chunk_size_t o_size,
    output logic [2:0]  o_incr
);

    always_comb begin
        o_size = SZ_BYTE;
        o_incr = 3'd1;
        if (i_x == 2'b00 && i_rem >= 12'd4) begin
            o_size = SZ_WORD;
            o_incr = 3'd4;
        end else if (!i_x[0] && i_rem >= 12'd2) begin
            o_size = SZ_HALF;
            o_incr = 3'd2;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rect_fill_blitter.sv
// ============================================================================
// Module   : rect_fill_blitter
// Brief    : Clips one rectangle-fill command to the framebuffer and streams
//            aligned byte/half/word writes into displayMemory's write port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rect_fill_blitter
    import display_pkg::*;
#(
    parameter int unsigned FB_WIDTH  = c_FB_WIDTH,
    parameter int unsigned FB_HEIGHT = c_FB_HEIGHT,
    parameter logic [31:0] BASE_ADDR = c_BASE_ADDR
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_x,
    input  logic [9:0]  cmd_y,
    input  logic [10:0] cmd_w,
    input  logic [10:0] cmd_h,
    input  logic [7:0]  cmd_color,
    output logic        busy,
    output logic        done,
    output logic        wr_en_display,
    output logic        byteWrite,
    output logic        half_wordWrite,
    output logic        full_wordWrite,
    output logic [31:0] writeAddress,
    output logic [31:0] writeData
);

    localparam logic [11:0] c_W12     = 12'(FB_WIDTH);
    localparam logic [11:0] c_H12     = 12'(FB_HEIGHT);
    localparam logic [31:0] c_PITCH32 = 32'(FB_WIDTH);

    fill_state_t r_state;

    logic [9:0]  r_cx;
    logic [9:0]  r_cy;
    logic [10:0] r_cw;
    logic [10:0] r_ch;
    logic [7:0]  r_color;

    logic [11:0] r_x;
    logic [11:0] r_x_end;
    logic [11:0] r_y;
    logic [11:0] r_y_end;
    logic [31:0] r_row_addr;
    logic [31:0] r_addr;

    logic [11:0] w_x_sum;
    logic [11:0] w_y_sum;
    logic [11:0] w_x_end;
    logic [11:0] w_y_end;
    logic        w_empty;
    logic [31:0] w_row_addr;
    logic [11:0] w_rem;
    chunk_size_t w_size;
    logic [2:0]  w_incr;
    logic [11:0] w_x_next;
    logic        w_row_last;
    logic        w_more_rows;

    // 12-bit sums cannot overflow: 1023 + 2047 < 4096
    assign w_x_sum     = {2'b00, r_cx} + {1'b0, r_cw};
    assign w_y_sum     = {2'b00, r_cy} + {1'b0, r_ch};
    assign w_x_end     = (w_x_sum > c_W12) ? c_W12 : w_x_sum;
    assign w_y_end     = (w_y_sum > c_H12) ? c_H12 : w_y_sum;
    assign w_empty     = ({2'b00, r_cx} >= c_W12) || ({2'b00, r_cy} >= c_H12) ||
                         (r_cw == 11'd0) || (r_ch == 11'd0);
    assign w_row_addr  = BASE_ADDR + 32'(r_cy) * c_PITCH32 + 32'(r_cx);

    assign w_rem       = r_x_end - r_x;
    assign w_x_next    = r_x + {9'd0, w_incr};
    assign w_row_last  = (w_x_next >= r_x_end);
    assign w_more_rows = ((r_y + 12'd1) < r_y_end);

    rect_chunk_sel u_chunk_sel (
        .i_x    (r_x[1:0]),
        .i_rem  (w_rem),
        .o_size (w_size),
        .o_incr (w_incr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            cmd_ready      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            wr_en_display  <= 1'b0;
            byteWrite      <= 1'b0;
            half_wordWrite <= 1'b0;
            full_wordWrite <= 1'b0;
            writeAddress   <= 32'd0;
            writeData      <= 32'd0;
            r_cx           <= 10'd0;
            r_cy           <= 10'd0;
            r_cw           <= 11'd0;
            r_ch           <= 11'd0;
            r_color        <= 8'd0;
            r_x            <= 12'd0;
            r_x_end        <= 12'd0;
            r_y            <= 12'd0;
            r_y_end        <= 12'd0;
            r_row_addr     <= 32'd0;
            r_addr         <= 32'd0;
        end else begin
            done           <= 1'b0;
            wr_en_display  <= 1'b0;
            byteWrite      <= 1'b0;
            half_wordWrite <= 1'b0;
            full_wordWrite <= 1'b0;
            case (r_state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        r_cx      <= cmd_x;
                        r_cy      <= cmd_y;
                        r_cw      <= cmd_w;
                        r_ch      <= cmd_h;
                        r_color   <= cmd_color;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_empty) begin
                        r_state <= DONE;
                    end else begin
                        r_x        <= {2'b00, r_cx};
                        r_x_end    <= w_x_end;
                        r_y        <= {2'b00, r_cy};
                        r_y_end    <= w_y_end;
                        r_row_addr <= w_row_addr;
                        r_addr     <= w_row_addr;
                        r_state    <= FILL;
                    end
                end
                FILL: begin
                    wr_en_display  <= 1'b1;
                    byteWrite      <= (w_size == SZ_BYTE);
                    half_wordWrite <= (w_size == SZ_HALF);
                    full_wordWrite <= (w_size == SZ_WORD);
                    writeAddress   <= r_addr;
                    writeData      <= {4{r_color}};
                    if (!w_row_last) begin
                        r_x    <= w_x_next;
                        r_addr <= r_addr + 32'(w_incr);
                    end else if (w_more_rows) begin
                        // Wrap straight into the next row so rows stream back to back
                        r_x        <= {2'b00, r_cx};
                        r_y        <= r_y + 12'd1;
                        r_row_addr <= r_row_addr + c_PITCH32;
                        r_addr     <= r_row_addr + c_PITCH32;
                    end else begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/rect_fill_blitter.md
Name: rect_fill_blitter

Overview:
Hardware fill engine upstream of displayMemory's write port. It accepts one rectangle-fill command (origin, size, 8-bit colour) over a valid/ready handshake. It clips the rectangle to the framebuffer and streams one aligned byte, half-word or word write per cycle into the write-side ports of displayMemory. HDMI_display keeps reading the read port concurrently and is unaffected.

Parameters:
FB_WIDTH, 320, pixels per row; 1 byte per pixel; row pitch = FB_WIDTH bytes; must be a multiple of 4.
FB_HEIGHT, 240, rows in the framebuffer.
BASE_ADDR, 32'h0000_0000, byte address of pixel (0,0); must be 4-byte aligned.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  engine can accept a command
cmd_x  in  10  left column
cmd_y  in  10  top row
cmd_w  in  11  width in pixels
cmd_h  in  11  height in pixels
cmd_color  in  8  fill colour
busy  out  1  command in progress
done  out  1  one-cycle pulse when a command completes
wr_en_display  out  1  write strobe to displayMemory
byteWrite  out  1  1-byte write
half_wordWrite  out  1  2-byte write
full_wordWrite  out  1  4-byte write
writeAddress  out  32  byte address of the write
writeData  out  32  {4{colour}}, always replicated; displayMemory selects the lane

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All outputs are registered.
- Reset values: cmd_ready=0 during rst and 1 on the first cycle after; busy=0, done=0, all write strobes 0, writeAddress=0, writeData=0. FSM goes to IDLE.
- FSM states and transitions:
  - IDLE: cmd_ready=1. Handshake is cmd_valid&&cmd_ready; the command is latched and the FSM moves to SETUP.
  - SETUP: busy=1, cmd_ready=0. Clip the rectangle:
    - x_end = min(cmd_x+cmd_w, FB_WIDTH); y_end = min(cmd_y+cmd_h, FB_HEIGHT), computed at 12-bit width with no overflow.
    - If cmd_x>=FB_WIDTH, cmd_y>=FB_HEIGHT, cmd_w==0 or cmd_h==0, go to DONE with zero writes.
    - Otherwise row_addr = BASE_ADDR + cmd_y*FB_WIDTH + cmd_x, then go to FILL.
  - FILL: emit one write per cycle, no bubbles. Chunk choice from the current x and rem = x_end - x:
    - x%4==0 and rem>=4: word.
    - else x%2==0 and rem>=2: half-word.
    - else: byte.
    - Assert wr_en_display plus exactly one size strobe; writeAddress = row_addr + (x - x_start). Advance x by the chunk size.
    - After the last chunk of a row: if y+1 < y_end, the next cycle's write is the first chunk of the next row (address advanced by FB_WIDTH, no idle cycle). Otherwise go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, strobes 0. Then IDLE, with cmd_ready=1 on the following cycle.
- Latency: command accepted at edge N; first write appears on outputs at edge N+2; done is asserted the cycle after the last write.
- Size strobes are mutually exclusive and are 0 whenever wr_en_display=0.
- Commands presented while not in IDLE are ignored (cmd_ready=0). They are not queued.
- Reset mid-command: strobes drop at the reset edge, the command is discarded and no done pulse is issued.

Decomposition:
- Package display_pkg holds:
  - FB_WIDTH and FB_HEIGHT defaults and BASE_ADDR;
  - the FSM state enum {IDLE, SETUP, FILL, DONE};
  - the chunk-size enum {SZ_BYTE, SZ_HALF, SZ_WORD}.
- One combinational sub-module, rect_chunk_sel: inputs x[1:0] and rem, outputs the chunk size and byte increment. Reused by the future copy/blit engine.

Test Plan:
1. Aligned fill: x=0, y=0, w=4, h=2, colour 8'hA5 -> exactly 2 full-word writes at addresses 0 and 320, writeData 32'hA5A5A5A5. done is one pulse 1 cycle after the second write; cmd_ready is back the cycle after that.
2. Unaligned row: x=1, y=0, w=6, h=1 -> four writes on consecutive cycles:
   - byte@1
   - half@2
   - half@4
   - byte@6
3. Clipping: x=318, y=239, w=10, h=10 -> single half-word write at 239*320+318 = 76798, then done.
4. Degenerate commands: w=0; then x=400 -> no writes in either case, done 2 cycles after each handshake.
5. Back-pressure: cmd_valid held high through a 3x3 fill at x=2 -> second command is not accepted until IDLE. Per row: half@x=2 then byte@x=4. Rows are contiguous with no gap cycles.
6. Reset after the 3rd write of a 4x4 fill -> strobes 0 at the reset edge, no done, cmd_ready=1 the cycle after rst deasserts, and the next command executes normally.
